// File: rtl/ctrl_unit_irq.sv
// Instruction decoder and control unit with vectored, maskable interrupt entry.
// Carry/zero flags are shadowed on interrupt entry and restored by RETI.
module ctrl_unit_irq #(
    parameter int               NUM_IRQ    = 4,
    parameter int               VEC_W      = 8,
    parameter logic [VEC_W-1:0] VEC_BASE   = 8'hF0,
    parameter int               VEC_STRIDE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               z_flag,
    input  logic               c_flag,
    input  logic               stall,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic [3:0]         alu_opcode,
    output logic               mux_reg_mem_write,
    output logic               mux_skip_alu_out,
    output logic               pc_en,
    output logic               reg_write_en,
    output logic               mux_load_imm,
    output logic               mem_write_en,
    output logic               mux_pc_branch,
    output logic               c_cond,
    output logic               call,
    output logic               ret,
    output logic               mux_irq_vec,
    output logic [VEC_W-1:0]   irq_vec,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               ie
);

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_IRQ_ENTRY = 1'b1
    } state_t;

    state_t             state_s;
    logic               carry_r;
    logic               zero_r;
    logic               ie_r;
    logic               ei_pend_r;
    logic [1:0]         shadow_r;
    logic [NUM_IRQ-1:0] pend_r;
    logic [NUM_IRQ-1:0] irq_prev_r;
    logic [NUM_IRQ-1:0] req_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [NUM_IRQ-1:0] sel_onehot_s;
    logic [2:0]         sel_idx_s;
    logic [VEC_W-1:0]   vec_off_s;
    logic               entry_s;

    logic [3:0] dec_alu_s;
    logic       dec_mrmw_s;
    logic       dec_msao_s;
    logic       dec_rwe_s;
    logic       dec_mli_s;
    logic       dec_mwe_s;
    logic       dec_mpb_s;
    logic       dec_call_s;
    logic       dec_ret_s;
    logic       is_alu_s;
    logic       is_reti_s;
    logic       is_di_s;
    logic       is_ei_s;

    assign req_s        = pend_r & irq_mask;
    assign rise_s       = irq & ~irq_prev_r;
    assign sel_onehot_s = NUM_IRQ'(1'b1) << sel_idx_s;
    assign vec_off_s    = VEC_W'(32'(sel_idx_s) * 32'(VEC_STRIDE));
    assign clr_s        = entry_s ? sel_onehot_s : {NUM_IRQ{1'b0}};
    // Entry replaces the current opcode; ie_r is 0 under reset, so reset also blocks it.
    assign entry_s      = rst & ie_r & (|req_s) & ~stall & ~ei_pend_r;
    assign state_s      = entry_s ? ST_IRQ_ENTRY : ST_RUN;
    assign c_cond       = carry_r;
    assign ie           = ie_r;

    // Lowest-index pending and enabled line wins.
    always_comb begin
        sel_idx_s = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_s[i]) begin
                sel_idx_s = 3'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // Plain opcode decode, before stall and interrupt overrides.
    always_comb begin
        dec_alu_s  = 4'b0000;
        dec_mrmw_s = 1'b0;
        dec_msao_s = 1'b0;
        dec_rwe_s  = 1'b0;
        dec_mli_s  = 1'b0;
        dec_mwe_s  = 1'b0;
        dec_mpb_s  = 1'b0;
        dec_call_s = 1'b0;
        dec_ret_s  = 1'b0;
        is_alu_s   = 1'b0;
        is_reti_s  = 1'b0;
        is_di_s    = 1'b0;
        is_ei_s    = 1'b0;
        casez (opcode)
            6'b0000??: begin dec_mpb_s = 1'b1; dec_call_s = 1'b1; end
            6'b0001??: dec_mpb_s = 1'b1;
            6'b001000: begin dec_mpb_s = 1'b1; dec_ret_s = 1'b1; end
            6'b001001: begin dec_mpb_s = 1'b1; dec_ret_s = 1'b1; is_reti_s = 1'b1; end
            6'b001010: is_di_s = 1'b1;
            6'b001011: is_ei_s = 1'b1;
            6'b001100: dec_mwe_s = 1'b1;
            6'b0100??: dec_mpb_s = zero_r;
            6'b0101??: dec_mpb_s = ~zero_r;
            6'b0110??: dec_mpb_s = carry_r;
            6'b0111??: dec_mpb_s = ~carry_r;
            6'b10????: begin dec_rwe_s = 1'b1; dec_mli_s = 1'b1; end
            6'b110000: begin dec_rwe_s = 1'b1; dec_msao_s = 1'b1; end
            6'b1111??: begin dec_rwe_s = 1'b1; dec_mrmw_s = 1'b1; end
            6'b110001: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b0111; end
            6'b110010: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b0101; end
            6'b110011: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b0100; end
            6'b110100: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b0000; end
            6'b110101: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b0010; end
            6'b110110: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b0001; end
            6'b110111: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b0011; end
            6'b111000: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b1000; end
            6'b111001: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b1101; end
            6'b111010: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b1100; end
            6'b111011: begin dec_rwe_s = 1'b1; is_alu_s = 1'b1; dec_alu_s = 4'b1011; end
            default:   dec_alu_s = 4'b0000;
        endcase
    end

    // Output stage: interrupt entry overrides decode, stall freezes side effects.
    always_comb begin
        alu_opcode        = dec_alu_s;
        mux_reg_mem_write = dec_mrmw_s;
        mux_skip_alu_out  = dec_msao_s;
        reg_write_en      = dec_rwe_s;
        mux_load_imm      = dec_mli_s;
        mem_write_en      = dec_mwe_s;
        mux_pc_branch     = dec_mpb_s;
        call              = dec_call_s;
        ret               = dec_ret_s;
        pc_en             = 1'b1;
        mux_irq_vec       = 1'b0;
        irq_vec           = {VEC_W{1'b0}};
        irq_ack           = {NUM_IRQ{1'b0}};
        case (state_s)
            ST_IRQ_ENTRY: begin
                alu_opcode        = 4'b0000;
                mux_reg_mem_write = 1'b0;
                mux_skip_alu_out  = 1'b0;
                reg_write_en      = 1'b0;
                mux_load_imm      = 1'b0;
                mem_write_en      = 1'b0;
                mux_pc_branch     = 1'b1;
                call              = 1'b1;
                ret               = 1'b0;
                mux_irq_vec       = 1'b1;
                irq_vec           = VEC_BASE + vec_off_s;
                irq_ack           = sel_onehot_s;
            end
            ST_RUN: begin
                if (stall) begin
                    pc_en         = 1'b0;
                    reg_write_en  = 1'b0;
                    mem_write_en  = 1'b0;
                    call          = 1'b0;
                    ret           = 1'b0;
                    mux_pc_branch = 1'b0;
                end else begin
                    pc_en         = 1'b1;
                end
            end
            default: pc_en = 1'b1;
        endcase
    end

    // Flags, interrupt enable, EI delay slot and flag shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_r   <= 1'b0;
            zero_r    <= 1'b0;
            ie_r      <= 1'b0;
            ei_pend_r <= 1'b0;
            shadow_r  <= 2'b00;
        end else if (entry_s) begin
            ie_r     <= 1'b0;
            shadow_r <= {carry_r, zero_r};
        end else if (!stall) begin
            if (is_alu_s) begin
                carry_r <= c_flag;
            end
            if (dec_rwe_s) begin
                zero_r <= z_flag;
            end
            if (is_reti_s) begin
                carry_r <= shadow_r[1];
                zero_r  <= shadow_r[0];
            end
            // EI takes effect once the instruction after it completes; a DI there cancels it.
            if (is_ei_s) begin
                ei_pend_r <= 1'b1;
            end else if (ei_pend_r) begin
                ei_pend_r <= 1'b0;
                ie_r      <= ~is_di_s;
            end else if (is_di_s) begin
                ie_r <= 1'b0;
            end else if (is_reti_s) begin
                ie_r <= 1'b1;
            end
        end
    end

    // Rising-edge capture of interrupt lines; a new edge beats the entry clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r     <= {NUM_IRQ{1'b0}};
            irq_prev_r <= {NUM_IRQ{1'b0}};
        end else begin
            pend_r     <= (pend_r & ~clr_s) | rise_s;
            irq_prev_r <= irq;
        end
    end

endmodule

// File: doc/ctrl_unit_irq.md
CTRL_UNIT_IRQ -- requirements
Module: ctrl_unit_irq

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of interrupt lines (legal 1..8).
REQ-002 SHALL have parameter VEC_W, default 8, interrupt vector address width.
REQ-003 SHALL have parameter VEC_BASE, default 8'hF0, vector address of line 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 1, vector spacing per line.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset (one clock; reset is asynchronous and active-low).
REQ-006 SHALL have inputs: opcode 6 current instruction; z_flag 1 and c_flag 1 ALU flags; stall 1 datapath wait; irq NUM_IRQ level lines; irq_mask NUM_IRQ per-line enable.
REQ-007 SHALL have outputs: alu_opcode 4; mux_reg_mem_write, mux_skip_alu_out, pc_en, reg_write_en, mux_load_imm, mem_write_en, mux_pc_branch, c_cond, call, ret 1 each.
REQ-008 SHALL have outputs: mux_irq_vec 1 (PC takes irq_vec); irq_vec VEC_W; irq_ack NUM_IRQ one-hot pulse; ie 1 interrupt-enable status.

Function
REQ-009 SHALL decode in RUN state: 0000xx CALL (mux_pc_branch, call); 0001xx GOTO (mux_pc_branch); 001000 RET (mux_pc_branch, ret); 001100 SW (mem_write_en).
REQ-010 SHALL decode 0100xx/0101xx/0110xx/0111xx as JPZ/JPNZ/JPC/JPNC, mux_pc_branch = zero_reg / ~zero_reg / carry_reg / ~carry_reg.
REQ-011 SHALL decode 10xxxx LWI (reg_write_en, mux_load_imm); 110000 MOV (reg_write_en, mux_skip_alu_out); 1111xx LW (reg_write_en, mux_reg_mem_write).
REQ-012 SHALL decode 110001..111011 as ALU ops with reg_write_en and alu_opcode XNOR 0111, OR 0101, AND 0100, ADD 0000, ADC 0010, SUB 0001, SBC 0011, ASR 1000, RRC 1101, ROR 1100, ROL 1011.
REQ-013 SHALL decode 001001 RETI (mux_pc_branch, ret; ie<=1; flags restored from shadow), 001010 DI (ie<=0), 001011 EI (ie set after the following instruction completes).
REQ-014 SHALL treat 001101..001111 as NOP; every output not asserted by a decode SHALL be 0 (no latches), pc_en=1, alu_opcode=0000.
REQ-015 SHALL drive c_cond = carry_reg; carry_reg <= c_flag on any ALU op; zero_reg <= z_flag on any cycle with reg_write_en=1.
REQ-016 SHALL set pend[i] on rising edge of irq[i] (registered previous level); set wins over clear of the same bit in the same cycle.
REQ-017 SHALL compute req = pend & irq_mask; selected line = lowest set index.
REQ-018 SHALL enter IRQ_ENTRY for one cycle, instead of executing opcode, when in RUN, ie=1, req!=0, stall=0, and no EI delay pending.
REQ-019 SHALL, in IRQ_ENTRY: call=1, mux_pc_branch=1, mux_irq_vec=1, pc_en=1, all write enables 0, irq_ack one-hot for selected line, irq_vec = VEC_BASE + index*VEC_STRIDE (mod 2^VEC_W); clear pend[index], ie<=0, shadow<={carry_reg,zero_reg}; flags unchanged; next state RUN.
REQ-020 SHALL drive irq_vec = 0 and irq_ack = 0 outside IRQ_ENTRY.
REQ-021 SHALL, while stall=1: pc_en=0, reg_write_en=0, mem_write_en=0, call=0, ret=0, mux_pc_branch=0; hold state, flags, ie, shadow; still capture pend edges.
REQ-022 SHALL let DI in the cycle an IRQ_ENTRY would occur lose priority: IRQ_ENTRY is taken, DI re-executes after return.

Reset
REQ-023 SHALL, on rst=0 asynchronously: state RUN, ie=0, EI delay cleared, carry_reg=zero_reg=0, shadow=0, pend=0, previous irq levels=0.
REQ-024 SHALL, during reset, drive decode outputs from opcode with flags at 0 and all irq outputs 0; reset mid-IRQ_ENTRY aborts entry with pend cleared.

Verification
REQ-025 SHALL cover: rst=0 mid-run with opcode=110100 -> ie=0, c_cond=0, pend=0, irq_ack=0 immediately.
REQ-026 SHALL cover: ADD with c_flag=1, z_flag=0, then JPC -> mux_pc_branch=1; then JPZ -> mux_pc_branch=0.
REQ-027 SHALL cover: EI, NOP, irq[1] and irq[2] rising together, mask=1111 -> IRQ_ENTRY after NOP, irq_ack=0010, irq_vec=0xF1, call=1; pend[2] remains 1.
REQ-028 SHALL cover: carry_reg=1 at entry, ISR SUB sets carry 0, RETI -> ret=1, ie=1, c_cond=1 next cycle; pending line 2 entered next eligible cycle with irq_vec=0xF2.
REQ-029 SHALL cover: stall=1 on SW with req!=0, ie=1 -> mem_write_en=0, pc_en=0, no entry; stall=0 -> IRQ_ENTRY.
REQ-030 SHALL cover: DI then irq[0] edge -> pend[0]=1, no entry; mask bit 0=0 with EI -> no entry; mask=1 -> entry with irq_vec=0xF0.
